// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter
// Two-master Wishbone B3 arbiter sharing the store-FIFO/Wishbone adapter
// port between the code (instruction fetch) and data masters.
// - Registered grant from a three-state FSM (IDLE, GNT_C, GNT_D); the grant is
//   held for the whole bus cycle, bursts included, and every grant is
//   separated by one dead IDLE cycle so the adapter always sees STB low.
// - ACK is routed only to the grant holder; read data is broadcast to both.
// - Saturating watchdog raises a sticky error when a granted strobe goes
//   WDT_CYCLES consecutive cycles without an ACK.
// Optional feature macro: ZAP_WB_ARB_RR_EN
//   defined   : round-robin tie-break (master not granted last wins a tie)
//   undefined : fixed priority, data wins every tie
module zap_wb_arbiter #(
  parameter int WDT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Code master
  input  logic        i_c_cyc,
  input  logic        i_c_stb,
  input  logic        i_c_we,
  input  logic [3:0]  i_c_sel,
  input  logic [2:0]  i_c_cti,
  input  logic [31:0] i_c_adr,
  input  logic [31:0] i_c_dat,
  output logic        o_c_ack,
  output logic [31:0] o_c_dat,
  // Data master
  input  logic        i_d_cyc,
  input  logic        i_d_stb,
  input  logic        i_d_we,
  input  logic [3:0]  i_d_sel,
  input  logic [2:0]  i_d_cti,
  input  logic [31:0] i_d_adr,
  input  logic [31:0] i_d_dat,
  output logic        o_d_ack,
  output logic [31:0] o_d_dat,
  // Adapter side
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  // Status
  output logic [1:0]  o_grant,
  output logic        o_wdt_err
);

  localparam int              CW        = $clog2(WDT_CYCLES) + 1;
  localparam logic [CW-1:0]   WDT_LIMIT = CW'(WDT_CYCLES);
  localparam logic [CW-1:0]   WDT_ONE   = CW'(1);

  // Encodings double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_C = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          c_req_s;
  logic          d_req_s;
  logic          pick_d_s;
  logic [CW-1:0] wdt_cnt_r;
  logic [CW-1:0] wdt_cnt_nxt_s;
  logic          wdt_err_r;

  assign c_req_s = i_c_cyc & i_c_stb;
  assign d_req_s = i_d_cyc & i_d_stb;

`ifdef ZAP_WB_ARB_RR_EN
  // Tie-break pointer: 1 favours data. Flips towards the master not just granted.
  logic rr_favor_d_r;

  // Round-robin pointer update on every IDLE to grant transition.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_favor_d_r <= 1'b1;
    end else if (state_r == IDLE && state_nxt_s == GNT_D) begin
      rr_favor_d_r <= 1'b0;
    end else if (state_r == IDLE && state_nxt_s == GNT_C) begin
      rr_favor_d_r <= 1'b1;
    end else begin
      rr_favor_d_r <= rr_favor_d_r;
    end
  end

  assign pick_d_s = rr_favor_d_r;
`else
  assign pick_d_s = 1'b1;
`endif

  // State register: the only source of the grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold a grant while its CYC stays high.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (c_req_s && d_req_s) begin
          state_nxt_s = pick_d_s ? GNT_D : GNT_C;
        end else if (d_req_s) begin
          state_nxt_s = GNT_D;
        end else if (c_req_s) begin
          state_nxt_s = GNT_C;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_C: begin
        if (i_c_cyc) begin
          state_nxt_s = GNT_C;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_D: begin
        if (i_d_cyc) begin
          state_nxt_s = GNT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bus mux and ACK routing: copy the grant holder, everything low in IDLE.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_sel = 4'h0;
    o_wb_cti = 3'b000;
    o_wb_adr = 32'h0000_0000;
    o_wb_dat = 32'h0000_0000;
    o_c_ack  = 1'b0;
    o_d_ack  = 1'b0;
    case (state_r)
      GNT_C: begin
        o_wb_cyc = i_c_cyc;
        o_wb_stb = i_c_stb;
        o_wb_we  = i_c_we;
        o_wb_sel = i_c_sel;
        o_wb_cti = i_c_cti;
        o_wb_adr = i_c_adr;
        o_wb_dat = i_c_dat;
        o_c_ack  = i_wb_ack;
      end
      GNT_D: begin
        o_wb_cyc = i_d_cyc;
        o_wb_stb = i_d_stb;
        o_wb_we  = i_d_we;
        o_wb_sel = i_d_sel;
        o_wb_cti = i_d_cti;
        o_wb_adr = i_d_adr;
        o_wb_dat = i_d_dat;
        o_d_ack  = i_wb_ack;
      end
      default: begin
        o_c_ack = 1'b0;
        o_d_ack = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; only the routed ACK qualifies it.
  assign o_c_dat = i_wb_dat;
  assign o_d_dat = i_wb_dat;

  // Watchdog next count: clear in IDLE or on ACK, count un-ACKed strobes, saturate.
  always_comb begin
    wdt_cnt_nxt_s = wdt_cnt_r;
    if (state_r == IDLE || i_wb_ack) begin
      wdt_cnt_nxt_s = '0;
    end else if (o_wb_stb && (wdt_cnt_r != WDT_LIMIT)) begin
      wdt_cnt_nxt_s = wdt_cnt_r + WDT_ONE;
    end else begin
      wdt_cnt_nxt_s = wdt_cnt_r;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wdt_cnt_r <= '0;
    end else begin
      wdt_cnt_r <= wdt_cnt_nxt_s;
    end
  end

  // Sticky watchdog error, set on the edge the count reaches the limit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wdt_err_r <= 1'b0;
    end else if (wdt_cnt_nxt_s == WDT_LIMIT) begin
      wdt_err_r <= 1'b1;
    end else begin
      wdt_err_r <= wdt_err_r;
    end
  end

  assign o_grant   = {state_r == GNT_D, state_r == GNT_C};
  assign o_wdt_err = wdt_err_r;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter (WDT_CYCLES = 8). Read data expected by a
// master is queued when the adapter model drives it and popped on the ACK.
module tb_zap_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_cyc, c_stb, c_we;
  logic [3:0]  c_sel;
  logic [2:0]  c_cti;
  logic [31:0] c_adr, c_dat;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [2:0]  d_cti;
  logic [31:0] d_adr, d_dat;
  logic        c_ack, d_ack;
  logic [31:0] c_rdat, d_rdat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [31:0] wb_adr, wb_wdat;
  logic        wb_ack;
  logic [31:0] wb_rdat;
  logic [1:0]  grant;
  logic        wdt_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [1:0]  tie_exp [3];

  zap_wb_arbiter #(.WDT_CYCLES(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_c_cyc(c_cyc), .i_c_stb(c_stb), .i_c_we(c_we), .i_c_sel(c_sel),
    .i_c_cti(c_cti), .i_c_adr(c_adr), .i_c_dat(c_dat),
    .o_c_ack(c_ack), .o_c_dat(c_rdat),
    .i_d_cyc(d_cyc), .i_d_stb(d_stb), .i_d_we(d_we), .i_d_sel(d_sel),
    .i_d_cti(d_cti), .i_d_adr(d_adr), .i_d_dat(d_dat),
    .o_d_ack(d_ack), .o_d_dat(d_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
    .o_wb_cti(wb_cti), .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat),
    .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat),
    .o_grant(grant), .o_wdt_err(wdt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=<nothing queued>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv_c(input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    c_cyc = cyc; c_stb = cyc; c_we = 1'b0; c_sel = 4'hF;
    c_cti = cti; c_adr = adr; c_dat = 32'h0000_0000;
  endtask

  task automatic drv_d(input logic cyc, input logic [31:0] adr, input logic [2:0] cti,
                       input logic we, input logic [31:0] dat);
    d_cyc = cyc; d_stb = cyc; d_we = we; d_sel = 4'hF;
    d_cti = cti; d_adr = adr; d_dat = dat;
  endtask

  // Adapter model: drive ACK/data, queue the data when a master must receive it.
  task automatic adapter(input logic ack, input logic [31:0] dat, input logic expect_it);
    wb_ack  = ack;
    wb_rdat = dat;
    if (expect_it) sb.push_back(dat);
  endtask

  initial begin
`ifdef ZAP_WB_ARB_RR_EN
    tie_exp[0] = 2'b10; tie_exp[1] = 2'b01; tie_exp[2] = 2'b10;
`else
    tie_exp[0] = 2'b10; tie_exp[1] = 2'b10; tie_exp[2] = 2'b10;
`endif
    rst = 1'b1;
    drv_c(1'b0, 32'h0, 3'b000);
    drv_d(1'b0, 32'h0, 3'b000, 1'b0, 32'h0);
    adapter(1'b0, 32'h0, 1'b0);
    nxt(); nxt();
    rst = 1'b0;

    // Reset state
    smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_wdt", wdt_err, 1'b0);
    chk("rst_wb_cyc", wb_cyc, 1'b0);
    chk("rst_wb_stb", wb_stb, 1'b0);
    chk("rst_c_ack", c_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    nxt();

    // Single code read
    drv_c(1'b1, 32'h0000_1000, 3'b000);
    smp();
    chk("t1_req_grant", grant, 2'b00);
    chk("t1_req_stb", wb_stb, 1'b0);
    nxt();
    adapter(1'b1, 32'hDEAD_BEEF, 1'b1);
    smp();
    chk("t1_grant", grant, 2'b01);
    chk("t1_adr", wb_adr, 32'h0000_1000);
    chk("t1_stb", wb_stb, 1'b1);
    chk("t1_c_ack", c_ack, 1'b1);
    sb_chk("t1_c_dat", c_rdat);
    chk("t1_d_ack", d_ack, 1'b0);
    nxt();
    drv_c(1'b0, 32'h0, 3'b000);
    adapter(1'b0, 32'h0, 1'b0);
    smp();
    chk("t1_rel_grant", grant, 2'b01);
    chk("t1_rel_cyc", wb_cyc, 1'b0);
    nxt();
    smp();
    chk("t1_idle", grant, 2'b00);
    nxt();

    // Data burst with code requesting throughout
    drv_d(1'b1, 32'h0000_2000, 3'b010, 1'b1, 32'hD000_0000);
    drv_c(1'b1, 32'h0000_3000, 3'b000);
    smp();
    chk("t2_req_grant", grant, 2'b00);
    nxt();
    for (int i = 0; i < 4; i++) begin
      drv_d(1'b1, 32'h0000_2000 + 32'(4 * i), (i == 3) ? 3'b111 : 3'b010, 1'b1,
            32'hD000_0000 + 32'(i));
      adapter(1'b1, 32'hB000_0000 + 32'(i), 1'b1);
      smp();
      chk("t2_grant", grant, 2'b10);
      chk("t2_adr", wb_adr, 32'h0000_2000 + 32'(4 * i));
      chk("t2_wdat", wb_wdat, 32'hD000_0000 + 32'(i));
      chk("t2_we", wb_we, 1'b1);
      chk("t2_d_ack", d_ack, 1'b1);
      sb_chk("t2_d_dat", d_rdat);
      chk("t2_c_ack", c_ack, 1'b0);
      nxt();
    end
    drv_d(1'b0, 32'h0, 3'b000, 1'b0, 32'h0);
    adapter(1'b0, 32'h0, 1'b0);
    smp();
    chk("t2_rel_grant", grant, 2'b10);
    nxt();
    smp();
    chk("t2_dead_grant", grant, 2'b00);
    chk("t2_dead_stb", wb_stb, 1'b0);
    nxt();
    adapter(1'b1, 32'hC0DE_0001, 1'b1);
    smp();
    chk("t2_c_grant", grant, 2'b01);
    chk("t2_c_adr", wb_adr, 32'h0000_3000);
    chk("t2_c_ack", c_ack, 1'b1);
    sb_chk("t2_c_dat", c_rdat);
    nxt();
    drv_c(1'b0, 32'h0, 3'b000);
    adapter(1'b0, 32'h0, 1'b0);
    nxt();
    smp();
    chk("t2_idle", grant, 2'b00);
    nxt();

    // Three back-to-back ties
    for (int r = 0; r < 3; r++) begin
      drv_c(1'b1, 32'h0000_4000 + 32'(r), 3'b000);
      drv_d(1'b1, 32'h0000_5000 + 32'(r), 3'b000, 1'b0, 32'h0);
      smp();
      chk("t3_idle", grant, 2'b00);
      nxt();
      adapter(1'b1, 32'hA000_0000 + 32'(r), 1'b1);
      smp();
      chk("t3_grant", grant, tie_exp[r]);
      chk("t3_d_ack", d_ack, tie_exp[r][1]);
      chk("t3_c_ack", c_ack, tie_exp[r][0]);
      sb_chk("t3_dat", tie_exp[r][1] ? d_rdat : c_rdat);
      nxt();
      if (tie_exp[r][1]) drv_d(1'b0, 32'h0, 3'b000, 1'b0, 32'h0);
      else drv_c(1'b0, 32'h0, 3'b000);
      adapter(1'b0, 32'h0, 1'b0);
      smp();
      chk("t3_rel_grant", grant, tie_exp[r]);
      nxt();
    end
    smp();
    chk("t3_after_idle", grant, 2'b00);
    nxt();
    adapter(1'b1, 32'hA000_00FF, 1'b1);
    smp();
    chk("t3_code_grant", grant, 2'b01);
    chk("t3_code_ack", c_ack, 1'b1);
    sb_chk("t3_code_dat", c_rdat);
    nxt();
    drv_c(1'b0, 32'h0, 3'b000);
    adapter(1'b0, 32'h0, 1'b0);
    nxt();
    smp();
    chk("t3_end_idle", grant, 2'b00);
    nxt();

    // Watchdog: ACK on cycle 7 keeps the error clear
    drv_c(1'b1, 32'h0000_6000, 3'b000);
    nxt();
    for (int k = 1; k <= 6; k++) begin
      smp();
      chk("t4a_wdt", wdt_err, 1'b0);
      chk("t4a_grant", grant, 2'b01);
      nxt();
    end
    adapter(1'b1, 32'h0000_0077, 1'b1);
    smp();
    chk("t4a_ack", c_ack, 1'b1);
    sb_chk("t4a_dat", c_rdat);
    nxt();
    drv_c(1'b0, 32'h0, 3'b000);
    adapter(1'b0, 32'h0, 1'b0);
    smp();
    chk("t4a_wdt_rel", wdt_err, 1'b0);
    nxt();
    smp();
    chk("t4a_wdt_idle", wdt_err, 1'b0);
    nxt();

    // Watchdog: eight un-ACKed cycles fire it, grant kept, error sticky
    drv_c(1'b1, 32'h0000_7000, 3'b000);
    nxt();
    for (int k = 1; k <= 8; k++) begin
      smp();
      chk("t4b_wdt_pre", wdt_err, 1'b0);
      chk("t4b_grant", grant, 2'b01);
      nxt();
    end
    smp();
    chk("t4b_wdt_fire", wdt_err, 1'b1);
    chk("t4b_grant_kept", grant, 2'b01);
    chk("t4b_stb_kept", wb_stb, 1'b1);
    nxt();
    adapter(1'b1, 32'h0000_0088, 1'b1);
    smp();
    chk("t4b_late_ack", c_ack, 1'b1);
    sb_chk("t4b_late_dat", c_rdat);
    chk("t4b_wdt_ack", wdt_err, 1'b1);
    nxt();
    drv_c(1'b0, 32'h0, 3'b000);
    adapter(1'b0, 32'h0, 1'b0);
    nxt();
    smp();
    chk("t4b_idle", grant, 2'b00);
    chk("t4b_wdt_sticky", wdt_err, 1'b1);
    nxt();

    // Reset during beat 2 of a data burst
    drv_d(1'b1, 32'h0000_8000, 3'b010, 1'b0, 32'h0);
    nxt();
    adapter(1'b1, 32'h0000_0B01, 1'b1);
    smp();
    chk("t5_beat1_ack", d_ack, 1'b1);
    sb_chk("t5_beat1_dat", d_rdat);
    nxt();
    drv_d(1'b1, 32'h0000_8004, 3'b010, 1'b0, 32'h0);
    adapter(1'b1, 32'h0000_0B02, 1'b0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    drv_d(1'b0, 32'h0, 3'b000, 1'b0, 32'h0);
    adapter(1'b1, 32'h0000_0B03, 1'b0);
    smp();
    chk("t5_grant", grant, 2'b00);
    chk("t5_cyc", wb_cyc, 1'b0);
    chk("t5_stb", wb_stb, 1'b0);
    chk("t5_d_ack", d_ack, 1'b0);
    chk("t5_c_ack", c_ack, 1'b0);
    chk("t5_wdt", wdt_err, 1'b0);
    nxt();
    adapter(1'b0, 32'h0, 1'b0);
    nxt();

    // Stray ACK in IDLE
    adapter(1'b1, 32'h1234_5678, 1'b0);
    smp();
    chk("t6_c_ack", c_ack, 1'b0);
    chk("t6_d_ack", d_ack, 1'b0);
    chk("t6_d_dat_pass", d_rdat, 32'h1234_5678);
    chk("t6_c_dat_pass", c_rdat, 32'h1234_5678);
    nxt();
    adapter(1'b0, 32'h0, 1'b0);
    smp();
    chk("t6_grant", grant, 2'b00);
    chk("t6_wdt", wdt_err, 1'b0);
    nxt();

    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
